// File: rtl/pokey_irq_pkg.sv
// pokey_irq_pkg: IRQST bit positions and idle value shared by the POKEY interrupt unit.
package pokey_irq_pkg;
    localparam int IRQ_BRK   = 7;
    localparam int IRQ_KBD   = 6;
    localparam int IRQ_SIN   = 5;
    localparam int IRQ_SOUT  = 4;
    localparam int IRQ_SDONE = 3;
    localparam int IRQ_T4    = 2;
    localparam int IRQ_T2    = 1;
    localparam int IRQ_T1    = 0;
    localparam logic [7:0] IRQST_IDLE = 8'hFF;
endpackage

// File: rtl/pokey_irq_ctrl_irq_edge_latch.sv
// irq_edge_latch: rising-edge detect plus enable-masked active-low pending latch for one IRQST bit.
// Optional POKEY_IRQ_OVERRUN_CNT_EN adds the ovr output (event while already pending).
module irq_edge_latch (
    input  logic clk179,
    input  logic rst_L,
    input  logic src,
    input  logic en_next,
    output logic st
`ifdef POKEY_IRQ_OVERRUN_CNT_EN
    ,
    output logic ovr
`endif
);
    logic prev;
    logic ev;
    assign ev = src & ~prev;
    // a disabled bit is forced idle, so a clearing write wins over a same-cycle event
    always_ff @(posedge clk179 or negedge rst_L) begin
        if (!rst_L) begin
            prev <= 1'b0;
            st   <= 1'b1;
        end else begin
            prev <= src;
            st   <= !en_next ? 1'b1 : ev ? 1'b0 : st;
        end
    end
`ifdef POKEY_IRQ_OVERRUN_CNT_EN
    assign ovr = en_next & ev & ~st;
`endif
endmodule

// File: rtl/pokey_irq_ctrl.sv
// pokey_irq_ctrl: synchronous POKEY IRQEN register, IRQST latches and active-low IRQ line.
// Optional POKEY_IRQ_OVERRUN_CNT_EN adds a saturating overrun_cnt output.
module pokey_irq_ctrl
    import pokey_irq_pkg::*;
#(
    parameter int         BRK_SYNC_STAGES = 2,
    parameter logic [7:0] IRQEN_RESET     = 8'h00
) (
    input  logic       clk179,
    input  logic       rst_L,
    input  logic       irqen_wr,
    input  logic [7:0] irqen_data,
    input  logic       brk_req,
    input  logic       kbd_pending,
    input  logic       ser_in_pending,
    input  logic       ser_out_pending,
    input  logic       ser_out_done,
    input  logic       timer4_pending,
    input  logic       timer2_pending,
    input  logic       timer1_pending,
    output logic [7:0] IRQEN_q,
    output logic [7:0] IRQ_ST,
    output logic       IRQ_L
`ifdef POKEY_IRQ_OVERRUN_CNT_EN
    ,
    output logic [7:0] overrun_cnt
`endif
);
    logic [BRK_SYNC_STAGES-1:0] brk_sync;
    logic [7:0] src;
`ifdef POKEY_IRQ_OVERRUN_CNT_EN
    logic [7:0] ovr;
`endif
    always_ff @(posedge clk179 or negedge rst_L) begin
        if (!rst_L) begin
            brk_sync <= '0;
            IRQEN_q  <= IRQEN_RESET;
        end else begin
            brk_sync <= {brk_sync[BRK_SYNC_STAGES-2:0], brk_req};
            IRQEN_q  <= irqen_wr ? irqen_data : IRQEN_q;
        end
    end
    assign src = {brk_sync[BRK_SYNC_STAGES-1], kbd_pending, ser_in_pending, ser_out_pending,
                  ser_out_done, timer4_pending, timer2_pending, timer1_pending};
    for (genvar i = 0; i < 8; i++) begin : g_bit
        if (i == IRQ_SDONE) begin : g_level
            // serial-done is a live level, never latched or masked in IRQST
            assign IRQ_ST[i] = ~src[i];
`ifdef POKEY_IRQ_OVERRUN_CNT_EN
            assign ovr[i] = 1'b0;
`endif
        end else begin : g_latch
            irq_edge_latch u_latch (
                .clk179 (clk179),
                .rst_L  (rst_L),
                .src    (src[i]),
                .en_next(irqen_wr ? irqen_data[i] : IRQEN_q[i]),
                .st     (IRQ_ST[i])
`ifdef POKEY_IRQ_OVERRUN_CNT_EN
                ,
                .ovr    (ovr[i])
`endif
            );
        end
    end
    assign IRQ_L = ~|(~IRQ_ST & IRQEN_q);
`ifdef POKEY_IRQ_OVERRUN_CNT_EN
    always_ff @(posedge clk179 or negedge rst_L) begin
        if (!rst_L) overrun_cnt <= 8'h00;
        else if (irqen_wr) overrun_cnt <= 8'h00;
        else if (|ovr && overrun_cnt != IRQST_IDLE) overrun_cnt <= overrun_cnt + 8'd1;
    end
`endif
endmodule
